// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access size codes,
// FSM state encoding, wait counter width and lane helpers.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Byte write enables for an access of the given size at the given lane.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-justified store data onto every lane it could occupy.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] w;
        case (size)
            SZ_BYTE: w = {4{wdata[7:0]}};
            SZ_HALF: w = {2{wdata[15:0]}};
            default: w = wdata;
        endcase
        return w;
    endfunction

    // Shift the addressed lane down to bit 0 and zero the unused upper bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {lane, 3'b000};
        case (size)
            SZ_BYTE: r = {24'd0, sh[7:0]};
            SZ_HALF: r = {16'd0, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// Word-organised single-port SRAM with per-byte write enable and a
// registered read port. Contents are deliberately left unreset.
module dmem_sram_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_en,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] mem_r [DEPTH_WORDS];
    logic [31:0] rdata_r;

    // Byte-masked write and synchronous read of the addressed word.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    mem_r[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
            rdata_r <= mem_r[i_addr];
        end
    end

    assign o_rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one sized load/store at a time over valid/ready,
// configurable wait states, single-cycle response pulse with error flag.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic        o_rvalid,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic NO_WAIT_C = (WAIT_CYCLES == 0);
    localparam logic [CNT_W-1:0] CNT_INIT_C =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : {CNT_W{1'b0}};

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             we_r;
    logic [1:0]       size_r;
    logic [31:0]      addr_r;
    logic [31:0]      wdata_r;
    logic             ready_r;
    logic             rvalid_r;
    logic             err_r;
    logic             load_r;

    logic             we_eff_s;
    logic [1:0]       size_eff_s;
    logic [31:0]      addr_eff_s;
    logic [31:0]      wdata_eff_s;
    logic             err_s;
    logic             commit_s;
    logic [31:0]      sram_q_s;

    // With zero wait states the commit edge is the accept edge, so the live
    // request fields are used in IDLE and the latched copy otherwise.
    always_comb begin
        if (state_r == ST_IDLE) begin
            we_eff_s    = i_we;
            size_eff_s  = i_size;
            addr_eff_s  = i_addr;
            wdata_eff_s = i_wdata;
        end else begin
            we_eff_s    = we_r;
            size_eff_s  = size_r;
            addr_eff_s  = addr_r;
            wdata_eff_s = wdata_r;
        end
    end

    // Illegal size, misalignment and out-of-range detection.
    always_comb begin
        case (size_eff_s)
            SZ_BYTE: err_s = 1'b0;
            SZ_HALF: err_s = addr_eff_s[0];
            SZ_WORD: err_s = (addr_eff_s[1:0] != 2'b00);
            default: err_s = 1'b1;
        endcase
        if (addr_eff_s[31:2] >= 30'(DEPTH_WORDS)) begin
            err_s = 1'b1;
        end else begin
            err_s = err_s;
        end
    end

    // The commit edge is the edge that enters RESP; held off during reset.
    always_comb begin
        if (state_r == ST_IDLE) begin
            commit_s = i_rst_n && i_req && NO_WAIT_C;
        end else if (state_r == ST_WAIT) begin
            commit_s = i_rst_n && (cnt_r == {CNT_W{1'b0}});
        end else begin
            commit_s = 1'b0;
        end
    end

    dmem_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_sram (
        .i_clk   (i_clk),
        .i_en    (commit_s && !err_s),
        .i_be    (we_eff_s ? byte_enable(size_eff_s, addr_eff_s[1:0]) : 4'b0000),
        .i_addr  (addr_eff_s[AW+1:2]),
        .i_wdata (lane_wdata(size_eff_s, wdata_eff_s)),
        .o_rdata (sram_q_s)
    );

    // Request FSM with registered handshake and response flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            we_r     <= 1'b0;
            size_r   <= 2'b00;
            addr_r   <= 32'd0;
            wdata_r  <= 32'd0;
            ready_r  <= 1'b1;
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
            load_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_req) begin
                        we_r    <= i_we;
                        size_r  <= i_size;
                        addr_r  <= i_addr;
                        wdata_r <= i_wdata;
                        ready_r <= 1'b0;
                        if (NO_WAIT_C) begin
                            state_r  <= ST_RESP;
                            rvalid_r <= 1'b1;
                            err_r    <= err_s;
                            load_r   <= !i_we && !err_s;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= CNT_INIT_C;
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r  <= ST_RESP;
                        rvalid_r <= 1'b1;
                        err_r    <= err_s;
                        load_r   <= !we_r && !err_s;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESP: begin
                    state_r  <= ST_IDLE;
                    ready_r  <= 1'b1;
                    rvalid_r <= 1'b0;
                    err_r    <= 1'b0;
                    load_r   <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    ready_r  <= 1'b1;
                    rvalid_r <= 1'b0;
                    err_r    <= 1'b0;
                    load_r   <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready  = ready_r;
    assign o_rvalid = rvalid_r;
    assign o_err    = err_r;
    assign o_rdata  = load_r ? load_extract(sram_q_s, size_r, addr_r[1:0]) : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: three responders (1, 0 and 15 wait states) checked
// against a byte-array memory model and handshake latency expectations.
module tb_dmem_responder;

    localparam int NDUT = 3;
    localparam int WC [NDUT] = '{1, 0, 15};
    localparam int MEM_BYTES = 4096;

    logic        clk;
    logic        rst_n;
    logic        req    [NDUT];
    logic        we     [NDUT];
    logic [1:0]  size   [NDUT];
    logic [31:0] addr   [NDUT];
    logic [31:0] wdata  [NDUT];
    logic        ready  [NDUT];
    logic        rvalid [NDUT];
    logic [31:0] rdata  [NDUT];
    logic        err    [NDUT];

    logic [7:0] mref  [NDUT][MEM_BYTES];
    bit         known [NDUT][MEM_BYTES];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS (1024),
            .WAIT_CYCLES (WC[g])
        ) u_dut (
            .i_clk    (clk),
            .i_rst_n  (rst_n),
            .i_req    (req[g]),
            .i_we     (we[g]),
            .i_size   (size[g]),
            .i_addr   (addr[g]),
            .i_wdata  (wdata[g]),
            .o_ready  (ready[g]),
            .o_rvalid (rvalid[g]),
            .o_rdata  (rdata[g]),
            .o_err    (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) ||
               (sz == 2'd2 && (a % 4) != 0) || (a >= 32'd4096);
    endfunction

    // One full transaction on DUT d: handshake, latency, data/err, recovery.
    task automatic do_req(input int d, input logic w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd);
        int  waitc;
        int  lat;
        bit  e;
        bit  all_known;
        int  n;
        logic [31:0] exp_data;
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; size[d] = sz; addr[d] = a; wdata[d] = wd;
        waitc = 0;
        while (ready[d] !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 50) check("ready_timeout", 32'(ready[d]), 32'd1);
        @(posedge clk);
        #1 req[d] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (rvalid[d] !== 1'b1 && lat < 40);
        check($sformatf("latency_d%0d", d), 32'(lat), 32'(WC[d] + 1));
        e = model_err(sz, a);
        n = (sz == 2'd3) ? 4 : (1 << sz);
        exp_data = 32'd0;
        all_known = 1'b1;
        if (!e && !w) begin
            for (int i = 0; i < n; i++) begin
                exp_data = exp_data | (32'(mref[d][a + i]) << (8 * i));
                if (!known[d][a + i]) all_known = 1'b0;
            end
        end
        check($sformatf("err_d%0d_a%h", d, a), 32'(err[d]), 32'(e));
        if (all_known) check($sformatf("rdata_d%0d_a%h", d, a), rdata[d], exp_data);
        if (w && !e) begin
            for (int i = 0; i < n; i++) begin
                mref[d][a + i]  = 8'((wd >> (8 * i)) & 32'hFF);
                known[d][a + i] = 1'b1;
            end
        end
        @(negedge clk);
        check("rvalid_one_cycle", 32'(rvalid[d]), 32'd0);
        check("ready_after_resp", 32'(ready[d]), 32'd1);
        check("rdata_idle_zero", rdata[d], 32'd0);
    endtask

    initial begin
        int c;
        logic [31:0] ra;
        for (int d = 0; d < NDUT; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; size[d] = 2'd0; addr[d] = 32'd0; wdata[d] = 32'd0;
            for (int i = 0; i < MEM_BYTES; i++) begin
                known[d][i] = 1'b0;
                mref[d][i]  = 8'd0;
            end
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready[0]), 32'd1);
        check("rst_rvalid", 32'(rvalid[0]), 32'd0);
        check("rst_rdata", rdata[0], 32'd0);
        check("rst_err", 32'(err[0]), 32'd0);
        rst_n = 1'b1;

        // Directed sequence on the one-wait-state responder.
        do_req(0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
        do_req(0, 1'b0, 2'd2, 32'h10, 32'd0);
        check("model_word", {mref[0][19], mref[0][18], mref[0][17], mref[0][16]}, 32'hDEADBEEF);
        do_req(0, 1'b1, 2'd0, 32'h13, 32'hFFFFFF5A);
        do_req(0, 1'b0, 2'd2, 32'h10, 32'd0);
        do_req(0, 1'b0, 2'd0, 32'h13, 32'd0);
        do_req(0, 1'b0, 2'd1, 32'h12, 32'd0);
        do_req(0, 1'b0, 2'd1, 32'h11, 32'd0);
        do_req(0, 1'b1, 2'd2, 32'h12, 32'h12345678);
        do_req(0, 1'b1, 2'd3, 32'h10, 32'h12345678);
        do_req(0, 1'b0, 2'd2, 32'h10, 32'd0);
        check("model_byte_merge", {mref[0][19], mref[0][18], mref[0][17], mref[0][16]}, 32'h5AADBEEF);
        do_req(0, 1'b0, 2'd2, 32'h1000, 32'd0);
        do_req(0, 1'b0, 2'd2, 32'h0FFC, 32'd0);
        do_req(0, 1'b1, 2'd1, 32'h0FFE, 32'hABCD1234);
        do_req(0, 1'b0, 2'd1, 32'h0FFE, 32'd0);

        // Reset during WAIT of a store must discard it.
        do_req(0, 1'b1, 2'd2, 32'h20, 32'h11111111);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; size[0] = 2'd2; addr[0] = 32'h20; wdata[0] = 32'h22222222;
        @(posedge clk);
        #1 req[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", 32'(ready[0]), 32'd1);
        check("rst_mid_rvalid", 32'(rvalid[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_rvalid", 32'(rvalid[0]), 32'd0);
        end
        do_req(0, 1'b0, 2'd2, 32'h20, 32'd0);

        // Randomised traffic on a pre-initialised window.
        for (int i = 0; i < 16; i++) do_req(0, 1'b1, 2'd2, 32'(i * 4), $urandom);
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? (32'h1000 + 32'($urandom_range(0, 4095))) :
                 32'($urandom_range(0, 63));
            do_req(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, $urandom);
        end

        // Zero wait states: continuous request gives accept every 2 cycles.
        do_req(1, 1'b1, 2'd2, 32'h10, 32'hCAFEF00D);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; size[1] = 2'd2; addr[1] = 32'h10;
        for (c = 0; c < 8; c++) begin
            check($sformatf("w0_ready_c%0d", c), 32'(ready[1]), 32'(c % 2 == 0));
            check($sformatf("w0_rvalid_c%0d", c), 32'(rvalid[1]), 32'(c % 2 == 1));
            if (c % 2 == 1) check("w0_rdata", rdata[1], 32'hCAFEF00D);
            @(negedge clk);
        end
        req[1] = 1'b0;
        do_req(1, 1'b0, 2'd0, 32'h11, 32'd0);

        // Fifteen wait states: 16-cycle latency.
        do_req(2, 1'b1, 2'd1, 32'h12, 32'h0000BEEF);
        do_req(2, 1'b0, 2'd1, 32'h12, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
